// File: rtl/camera_capture_pkg.sv
// Shared definitions for the OV7670 capture path: FSM encodings, bus widths,
// default frame geometry and the packed camera pin bundle.
// No logic; imported by camera_capture and cam_input_sync.
package camera_capture_pkg;

  // Pixel and coordinate widths.
  localparam int RGB565_W = 16;
  localparam int X_W      = 10;
  localparam int Y_W      = 9;

  // Default geometry (VGA) and synchronizer depth.
  localparam int DEF_H_RES   = 640;
  localparam int DEF_V_RES   = 480;
  localparam int DEF_SYNC_FF = 2;

  // Capture FSM states.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,  // waiting for setup_done_i
    ST_ARM     = 2'd1,  // waiting to see vertical blanking
    ST_WAIT_VS = 2'd2,  // in blanking, waiting for VSYNC to fall
    ST_CAPTURE = 2'd3   // active frame
  } cap_state_e;

  // Camera parallel bus. pclk is the MSB so the bus is built as
  // {pclk, vsync, href, data}.
  typedef struct packed {
    logic       pclk;
    logic       vsync;
    logic       href;
    logic [7:0] data;
  } cam_bus_t;

  // RGB565 arrives high byte first.
  function automatic logic [RGB565_W-1:0] rgb565_pack(input logic [7:0] hi,
                                                      input logic [7:0] lo);
    return {hi, lo};
  endfunction

endpackage

// File: rtl/camera_capture_input_sync.sv
// cam_input_sync: SYNC_FF-deep synchronizer for the camera bus plus edge detects.
// Latency: SYNC_FF clk_i cycles for levels; edges are combinational from the last stage.
// Backpressure: none; free-running sampler.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-low reset
//   cam_raw               raw {pclk, vsync, href, data} from the pins
//   vsync_s, href_s       synchronized levels
//   data_s                synchronized data, aligned with the PCLK edge detect
//   pclk_rise             synced PCLK is 1 and was 0 last cycle
//   vsync_rise/vsync_fall VSYNC edges
//   href_fall             HREF falling edge (end of line)
module cam_input_sync
  import camera_capture_pkg::*;
#(
  parameter int SYNC_FF = DEF_SYNC_FF
) (
  input  logic     clk_i,
  input  logic     rst_i,
  input  cam_bus_t cam_raw,
  output logic     vsync_s,
  output logic     href_s,
  output logic [7:0] data_s,
  output logic     pclk_rise,
  output logic     vsync_rise,
  output logic     vsync_fall,
  output logic     href_fall
);

  // All bus bits travel through the same number of stages so data stays
  // aligned with the PCLK edge that qualifies it.
  cam_bus_t stage_q [SYNC_FF];
  cam_bus_t last;

  logic pclk_d;
  logic vsync_d;
  logic href_d;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      for (int i = 0; i < SYNC_FF; i++) begin
        stage_q[i] <= '0;
      end
      pclk_d  <= 1'b0;
      vsync_d <= 1'b0;
      href_d  <= 1'b0;
    end else begin
      stage_q[0] <= cam_raw;
      for (int i = 1; i < SYNC_FF; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
      pclk_d  <= last.pclk;
      vsync_d <= last.vsync;
      href_d  <= last.href;
    end
  end

  assign last    = stage_q[SYNC_FF-1];
  assign vsync_s = last.vsync;
  assign href_s  = last.href;
  assign data_s  = last.data;

  assign pclk_rise  =  last.pclk  & ~pclk_d;
  assign vsync_rise =  last.vsync & ~vsync_d;
  assign vsync_fall = ~last.vsync &  vsync_d;
  assign href_fall  = ~last.href  &  href_d;

endmodule

// File: rtl/camera_capture.sv
// camera_capture: OV7670 parallel-bus capture, RGB565 byte pairs -> pixel strobes with X/Y.
// Latency: pixel strobe SYNC_FF+1 clk_i after the PCLK pin edge of the second byte.
// Backpressure: none; downstream must accept every pix_valid_o strobe.
//
// Ports:
//   clk_i, rst_i        main clock (>= 4x PCLK), synchronous active-low reset
//   setup_done_i        camera register setup finished; 0 forces IDLE
//   cam_pclk_i, cam_vsync_i, cam_href_i, cam_data_i   raw camera pins (async)
//   pix_o, pix_valid_o  RGB565 pixel and its one-cycle strobe
//   x_o, y_o            coordinates of the strobed pixel
//   sof_o               with the first pixel strobe of a frame
//   eof_o               one cycle when a captured frame ends (VSYNC rises)
//   err_o               sticky: odd byte count in a line or x/y overrun
//
// Build option: CAPTURE_DECIMATE_EN keeps only even-x/even-y pixels and reports
// halved coordinates.
module camera_capture
  import camera_capture_pkg::*;
#(
  parameter int H_RES   = DEF_H_RES,
  parameter int V_RES   = DEF_V_RES,
  parameter int SYNC_FF = DEF_SYNC_FF
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                setup_done_i,
  input  logic                cam_pclk_i,
  input  logic                cam_vsync_i,
  input  logic                cam_href_i,
  input  logic [7:0]          cam_data_i,
  output logic [RGB565_W-1:0] pix_o,
  output logic                pix_valid_o,
  output logic [X_W-1:0]      x_o,
  output logic [Y_W-1:0]      y_o,
  output logic                sof_o,
  output logic                eof_o,
  output logic                err_o
);

  localparam logic [X_W-1:0] H_LIM = X_W'(H_RES);
  localparam logic [Y_W-1:0] V_LIM = Y_W'(V_RES);

  // ---------------------------------------------------------------------------
  // Input synchronization
  // ---------------------------------------------------------------------------
  cam_bus_t   cam_raw;
  logic       vsync_s;
  logic       href_s;
  logic [7:0] data_s;
  logic       pclk_rise;
  logic       vsync_rise;
  logic       vsync_fall;
  logic       href_fall;

  assign cam_raw = {cam_pclk_i, cam_vsync_i, cam_href_i, cam_data_i};

  cam_input_sync #(
    .SYNC_FF (SYNC_FF)
  ) u_sync (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .cam_raw    (cam_raw),
    .vsync_s    (vsync_s),
    .href_s     (href_s),
    .data_s     (data_s),
    .pclk_rise  (pclk_rise),
    .vsync_rise (vsync_rise),
    .vsync_fall (vsync_fall),
    .href_fall  (href_fall)
  );

  // ---------------------------------------------------------------------------
  // Capture FSM
  // ---------------------------------------------------------------------------
  cap_state_e state_q;
  cap_state_e state_d;

  logic frame_start;  // WAIT_VS -> CAPTURE this cycle
  logic capture_act;  // bytes and line ends are processed this cycle
  logic frame_end;    // CAPTURE -> WAIT_VS this cycle, eof pulse follows

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!setup_done_i) begin
      // Losing setup aborts silently: no eof, partial pixel dropped.
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE:    state_d = ST_ARM;
        // Only start from blanking so a frame is never entered mid-way.
        ST_ARM:     if (vsync_s)    state_d = ST_WAIT_VS;
        ST_WAIT_VS: if (vsync_fall) state_d = ST_CAPTURE;
        ST_CAPTURE: if (vsync_rise) state_d = ST_WAIT_VS;
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    frame_start = (state_q == ST_WAIT_VS) && setup_done_i && vsync_fall;
    capture_act = (state_q == ST_CAPTURE) && setup_done_i;
    frame_end   = capture_act && vsync_rise;
  end

  // ---------------------------------------------------------------------------
  // Byte assembler and counters
  // ---------------------------------------------------------------------------
  logic           phase_q;     // 1 = high byte held, waiting for low byte
  logic [7:0]     hi_q;
  logic [X_W-1:0] x_q;         // raw column of the next pixel, saturates at H_RES
  logic [Y_W-1:0] y_q;         // raw row, saturates at V_RES
  logic           line_pix_q;  // current line completed at least one pixel
  logic           first_pix_q; // next emitted pixel carries sof

  logic           byte_stb;
  logic           in_range;
  logic           keep;
  logic [X_W-1:0] x_out;
  logic [Y_W-1:0] y_out;

  assign byte_stb = capture_act && pclk_rise && href_s;
  assign in_range = (x_q < H_LIM) && (y_q < V_LIM);

`ifdef CAPTURE_DECIMATE_EN
  assign keep  = in_range && !x_q[0] && !y_q[0];
  assign x_out = {1'b0, x_q[X_W-1:1]};
  assign y_out = {1'b0, y_q[Y_W-1:1]};
`else
  assign keep  = in_range;
  assign x_out = x_q;
  assign y_out = y_q;
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      pix_o       <= '0;
      pix_valid_o <= 1'b0;
      x_o         <= '0;
      y_o         <= '0;
      sof_o       <= 1'b0;
      eof_o       <= 1'b0;
      err_o       <= 1'b0;
      phase_q     <= 1'b0;
      hi_q        <= '0;
      x_q         <= '0;
      y_q         <= '0;
      line_pix_q  <= 1'b0;
      first_pix_q <= 1'b0;
    end else begin
      pix_valid_o <= 1'b0;
      sof_o       <= 1'b0;
      eof_o       <= 1'b0;

      if (!capture_act) begin
        phase_q    <= 1'b0;
        x_q        <= '0;
        line_pix_q <= 1'b0;
        if (frame_start) begin
          y_q         <= '0;
          first_pix_q <= 1'b1;
        end
      end else begin
        if (byte_stb) begin
          if (!phase_q) begin
            hi_q    <= data_s;
            phase_q <= 1'b1;
          end else begin
            phase_q    <= 1'b0;
            line_pix_q <= 1'b1;
            if (in_range) begin
              x_q <= x_q + 1'b1;
              if (keep) begin
                pix_o       <= rgb565_pack(hi_q, data_s);
                pix_valid_o <= 1'b1;
                x_o         <= x_out;
                y_o         <= y_out;
                sof_o       <= first_pix_q;
                first_pix_q <= 1'b0;
              end
            end else begin
              // Overrun: counters hold at the limit, pixel is dropped.
              err_o <= 1'b1;
            end
          end
        end

        // href_s is low whenever href_fall is set, so this never collides
        // with byte_stb above.
        if (href_fall) begin
          if (phase_q) begin
            err_o <= 1'b1;
          end
          phase_q    <= 1'b0;
          x_q        <= '0;
          line_pix_q <= 1'b0;
          if (line_pix_q && (y_q < V_LIM)) begin
            y_q <= y_q + 1'b1;
          end
        end

        // Line-end bookkeeping above completes in the same cycle.
        if (frame_end) begin
          eof_o <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_camera_capture.sv
// Testbench for camera_capture: directed frame scenarios plus random frames,
// checked against a per-pixel expectation queue built from the frame contents.
// Build with CAPTURE_DECIMATE_EN to exercise the decimated variant.
module tb_camera_capture;

  localparam int H = 4;
  localparam int V = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        setup_done;
  logic        cam_pclk;
  logic        cam_vsync;
  logic        cam_href;
  logic [7:0]  cam_data;
  logic [15:0] pix;
  logic        pix_valid;
  logic [9:0]  x;
  logic [8:0]  y;
  logic        sof;
  logic        eof;
  logic        err;

  always #5 clk = ~clk;

  camera_capture #(
    .H_RES   (H),
    .V_RES   (V),
    .SYNC_FF (2)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst_n),
    .setup_done_i (setup_done),
    .cam_pclk_i   (cam_pclk),
    .cam_vsync_i  (cam_vsync),
    .cam_href_i   (cam_href),
    .cam_data_i   (cam_data),
    .pix_o        (pix),
    .pix_valid_o  (pix_valid),
    .x_o          (x),
    .y_o          (y),
    .sof_o        (sof),
    .eof_o        (eof),
    .err_o        (err)
  );

  typedef struct {
    logic [15:0] pix;
    int          px;
    int          py;
    logic        sof;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   errors   = 0;
  int   eof_seen = 0;
  int   eof_exp  = 0;
  logic err_exp  = 1'b0;
  int   lens[6];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  // Output monitor: every strobe must match the head of the expectation queue.
  always @(negedge clk) begin
    if (eof) eof_seen++;
    if (sof) chk("sof_with_pix", {31'd0, pix_valid}, 32'd1);
    if (pix_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pix", {31'd0, pix_valid}, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("pix", {16'd0, pix}, {16'd0, e.pix});
        chk("x", {22'd0, x}, e.px);
        chk("y", {23'd0, y}, e.py);
        chk("sof", {31'd0, sof}, {31'd0, e.sof});
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_reset_outputs();
    chk("rst_pix", {16'd0, pix}, 32'd0);
    chk("rst_valid", {31'd0, pix_valid}, 32'd0);
    chk("rst_x", {22'd0, x}, 32'd0);
    chk("rst_y", {23'd0, y}, 32'd0);
    chk("rst_sof", {31'd0, sof}, 32'd0);
    chk("rst_eof", {31'd0, eof}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
  endtask

  // One PCLK period = 8 clk_i; pins change while PCLK is low.
  task automatic pclk_cycle(input logic vs, input logic hr, input logic [7:0] d);
    cam_vsync = vs;
    cam_href  = hr;
    cam_data  = d;
    cam_pclk  = 1'b0;
    repeat (4) @(negedge clk);
    cam_pclk = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs();
    rst_n = 1'b1;
  endtask

  // Drives one frame of lens[0..nl-1] bytes per line. Expected pixels are
  // pushed from the frame contents: pixel i of a line is bytes 2i,2i+1, its
  // row is the number of earlier lines that completed a pixel.
  task automatic drive_frame(input int nl, input bit capture, input bit fixed_pat,
                             input int en_line, input int rst_line, input int rst_byte);
    bit         live;
    bit         first;
    bit         keep;
    int         py;
    int         npix;
    logic [7:0] d;
    logic [7:0] hi;
    live  = capture;
    first = 1'b1;
    py    = 0;
    hi    = 8'h00;
    repeat (3) pclk_cycle(1'b1, 1'b0, 8'h00);
    repeat (2) pclk_cycle(1'b0, 1'b0, 8'h00);
    for (int l = 0; l < nl; l++) begin
      npix = 0;
      for (int b = 0; b < lens[l]; b++) begin
        if (l == en_line && b == 2) setup_done = 1'b1;
        if (l == rst_line && b == rst_byte) begin
          pulse_reset();
          live    = 1'b0;
          err_exp = 1'b0;
        end
        d = fixed_pat ? ((b % 2 == 0) ? 8'hF8 : 8'h00) : 8'($urandom);
        if (b % 2 == 0) begin
          hi = d;
        end else begin
          int px;
          px = b / 2;
          npix++;
          if (live) begin
            if (px < H && py < V) begin
              keep = 1'b1;
`ifdef CAPTURE_DECIMATE_EN
              keep = (px % 2 == 0) && (py % 2 == 0);
              if (keep) exp_q.push_back('{{hi, d}, px / 2, py / 2, first});
`else
              if (keep) exp_q.push_back('{{hi, d}, px, py, first});
`endif
              if (keep) first = 1'b0;
            end else begin
              err_exp = 1'b1;
            end
          end
        end
        pclk_cycle(1'b0, 1'b1, d);
      end
      if (live && (lens[l] % 2 == 1)) err_exp = 1'b1;
      if (npix > 0) py++;
      repeat (2) pclk_cycle(1'b0, 1'b0, 8'h00);
    end
    if (live) eof_exp++;
    repeat (2) pclk_cycle(1'b1, 1'b0, 8'h00);
    repeat (4) @(negedge clk);
    chk("frame_leftover", exp_q.size(), 32'd0);
    chk("eof_count", eof_seen, eof_exp);
    chk("err", {31'd0, err}, {31'd0, err_exp});
  endtask

  initial begin
    rst_n      = 1'b0;
    setup_done = 1'b0;
    cam_pclk   = 1'b0;
    cam_vsync  = 1'b0;
    cam_href   = 1'b0;
    cam_data   = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Setup not done: a full frame produces nothing.
    lens = '{8, 8, 8, 8, 0, 0};
    drive_frame(4, 1'b0, 1'b1, -1, -1, -1);

    // Setup done during blanking: F8 00 pattern, 2 lines of 4 pixels.
    setup_done = 1'b1;
    lens = '{8, 8, 0, 0, 0, 0};
    drive_frame(2, 1'b1, 1'b1, -1, -1, -1);

    // Enable in the middle of an active line: that frame is skipped.
    setup_done = 1'b0;
    repeat (4) @(negedge clk);
    lens = '{8, 8, 8, 8, 0, 0};
    drive_frame(4, 1'b0, 1'b0, 1, -1, -1);
    drive_frame(4, 1'b1, 1'b0, -1, -1, -1);

    // Odd byte count on the first line, normal second line.
    lens = '{7, 8, 0, 0, 0, 0};
    drive_frame(2, 1'b1, 1'b0, -1, -1, -1);

    // Reset mid-line; the rest of the frame is ignored, then a full frame.
    lens = '{8, 8, 8, 0, 0, 0};
    drive_frame(3, 1'b1, 1'b0, -1, 1, 2);
    lens = '{8, 8, 8, 8, 0, 0};
    drive_frame(4, 1'b1, 1'b0, -1, -1, -1);

    // Random frames, including x/y overruns and odd lines.
    for (int f = 0; f < 6; f++) begin
      int nl;
      nl = int'($urandom_range(1, 6));
      for (int l = 0; l < 6; l++) lens[l] = int'($urandom_range(0, 11));
      drive_frame(nl, 1'b1, 1'b0, -1, -1, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
